// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pkg.sv
// Shared constants for the 9-track 5 V multi-bit scan flop cells.
// Gate-mode encodings and legal bank widths live here so the cell wrapper and
// the per-bit gate agree on what a MODE value means.
package gf180mcu_fd_sc_mcu9t5v0_pkg;

  // Complex-gate flavour selected by the MODE parameter.
  localparam int MODE_AOI221 = 0;
  localparam int MODE_OAI221 = 1;

  // Legal number of channels (and flops) in one bank.
  localparam int MBFF_WIDTH_MIN = 1;
  localparam int MBFF_WIDTH_MAX = 16;

  // True when a bank width can be built.
  function automatic bit mbff_width_ok(input int width);
    return (width >= MBFF_WIDTH_MIN) && (width <= MBFF_WIDTH_MAX);
  endfunction

  // True when the mode selects one of the supported gate flavours.
  function automatic bit mbff_mode_ok(input int mode);
    return (mode == MODE_AOI221) || (mode == MODE_OAI221);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_mode_bit.sv
// Single-bit AOI221 / OAI221 gate, purely combinational.
// Built from gate primitives so that a controlling input masks an unknown on
// the others (AOI: C=1 forces 0, OAI: C=0 forces 1), matching the standalone
// combinational cells this bank replaces.
module gf180mcu_fd_sc_mcu9t5v0__aoi221_mode_bit
  import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
  parameter int MODE = MODE_AOI221
) (
  input  logic a1_i,
  input  logic a2_i,
  input  logic b1_i,
  input  logic b2_i,
  input  logic c_i,
  output wire  zn_o
);

  // First-level terms: A-pair and B-pair (AND for AOI, OR for OAI).
  wire pair_a;
  wire pair_b;

  generate
    if (MODE == MODE_OAI221) begin : g_oai
      // ZN = ~((A1|A2) & (B1|B2) & C)
      or   u_or_a (pair_a, a1_i, a2_i);
      or   u_or_b (pair_b, b1_i, b2_i);
      nand u_nand (zn_o, pair_a, pair_b, c_i);
    end else begin : g_aoi
      // ZN = ~((A1&A2) | (B1&B2) | C)
      and  u_and_a (pair_a, a1_i, a2_i);
      and  u_and_b (pair_b, b1_i, b2_i);
      nor  u_nor   (zn_o, pair_a, pair_b, c_i);
    end
  endgenerate

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_mbsdff.sv
// Multi-bit registered AOI221/OAI221 bank with an internal scan chain.
// Each channel's complex gate feeds a rising-edge flop. Next-state priority is
// reset > scan shift > functional load > hold. The chain enters at bit 0 and
// leaves at bit WIDTH-1, which is also the scan-out wire.
// All selection is written with conditional operators so that an unknown on
// RST, SE or E merges the candidate values bit by bit instead of silently
// picking one branch.
module gf180mcu_fd_sc_mcu9t5v0__aoi221_mbsdff
  import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODE    = MODE_AOI221,
  parameter bit RST_VAL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic             SE,
  input  logic             SI,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] ZN,
  output logic             SO
);

  // Refuse to build an unsupported bank.
  generate
    if (!mbff_width_ok(WIDTH)) begin : g_bad_width
      $error("aoi221_mbsdff: WIDTH must be within 1..16");
    end
    if (!mbff_mode_ok(MODE)) begin : g_bad_mode
      $error("aoi221_mbsdff: MODE must be 0 (AOI221) or 1 (OAI221)");
    end
  endgenerate

  logic [WIDTH-1:0] zn_q;     // flop bank
  logic [WIDTH-1:0] func_d;   // per-channel gate results
  logic [WIDTH-1:0] shift_d;  // chain shifted by one position
  logic [WIDTH-1:0] ld_d;     // next state when not in reset

  // One gate per channel; bit i of every input bus drives channel i.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      gf180mcu_fd_sc_mcu9t5v0__aoi221_mode_bit #(
        .MODE (MODE)
      ) u_bit (
        .a1_i (A1[gi]),
        .a2_i (A2[gi]),
        .b1_i (B1[gi]),
        .b2_i (B2[gi]),
        .c_i  (C[gi]),
        .zn_o (func_d[gi])
      );
    end
  endgenerate

  // Scan path: SI enters bit 0, every bit moves one place toward the MSB.
  // A one-flop bank has no upstream bit, so it just captures SI.
  generate
    if (WIDTH == 1) begin : g_chain_one
      assign shift_d = SI;
    end else begin : g_chain_many
      assign shift_d = {zn_q[WIDTH-2:0], SI};
    end
  endgenerate

  // Non-reset next state: shift wins over load, otherwise hold.
  always_comb begin
    ld_d = SE ? shift_d : (E ? func_d : zn_q);
  end

  // Flop bank with synchronous reset to the configured value.
  always_ff @(posedge CLK) begin
    zn_q <= RST ? {WIDTH{RST_VAL}} : ld_d;
  end

  assign ZN = zn_q;
  assign SO = zn_q[WIDTH-1];

endmodule
